pwm_sample_feeder: RTL
======================

Name: pwm_sample_feeder

Overview:
- Upstream feeder for the Wishbone PWM audio controller.
- The CPU writes audio samples over a Wishbone slave port into a sample FIFO.
- A Wishbone master port drains one sample into the PWM controller's data register (address 0) each time the controller raises its sample-request interrupt.
- The CPU therefore services audio in bursts rather than once per sample period.

Parameters:
- LGFIFO, 5, log2 of FIFO depth (32 entries); legal range 2..7.
- NAUX, 2, number of aux control bits carried in data[NAUX+19:20] of each sample word.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  CPU-side Wishbone slave strobes
- i_wb_addr  in  1  0 = FIFO/status, 1 = control
- i_wb_data  in  32  write data
- o_wb_ack  out  1  slave ack
- o_wb_stall  out  1  slave stall, tied 0
- o_wb_data  out  32  slave read data
- o_pwm_cyc, o_pwm_stb, o_pwm_we  out  1 each  master strobes toward the PWM controller
- o_pwm_addr  out  1  master address, always 0
- o_pwm_data  out  32  sample word being written
- i_pwm_ack, i_pwm_stall  in  1 each  master handshake
- i_pwm_int  in  1  PWM controller sample request (level, active-high)
- o_int  out  1  FIFO low-water interrupt to the CPU

Behaviour:
- Reset (async, any cycle): all outputs 0, FIFO empty, flags clear, enable=0, FSM to IDLE.
  - o_pwm_cyc drops immediately even mid-transaction.
- Slave port:
  - Never stalls; o_wb_ack = registered i_wb_stb (1-cycle latency).
  - o_wb_data is registered and valid with the ack.
- Address 0 write: push the 32-bit word if FIFO is not full; if full, drop it and set sticky OVF.
  - Push with a same-cycle pop while full is still dropped (full is evaluated before the pop).
- Address 1 write controls:
  - bit0 ENABLE.
  - bit1 CLEAR: empties the FIFO; a same-cycle push is dropped.
  - bit2 CLRFLAGS: clears OVF/UNF; a same-cycle set wins.
- Address 0 read returns:
  - [LGFIFO+8:8] fill count.
  - bit4 OVF, bit3 UNF, bit2 full, bit1 empty, bit0 ENABLE.
- Address 1 read returns {31'b0, ENABLE}.
- o_int = ENABLE & (fill < 2**(LGFIFO-1)), registered.
- Master FSM states: IDLE, BUS, WAIT, HOLD.
  - IDLE -> BUS when ENABLE & i_pwm_int.
    - On this transition, if the FIFO is non-empty, pop its head into o_pwm_data.
    - Otherwise load 32'h0 (midscale, aux unchanged because bit16=0) and set sticky UNF.
    - Raise cyc, stb and we.
  - BUS: hold stb and data until !i_pwm_stall.
    - If i_pwm_ack is also high that cycle, go to HOLD; otherwise go to WAIT with stb=0, cyc=1.
  - WAIT: on i_pwm_ack, drop cyc and go to HOLD.
  - HOLD: exactly 1 cycle, so the controller's interrupt can deassert, then go to IDLE.
    - Guarantees one write per request.
- Clearing ENABLE mid-transaction does not abort it; the FSM completes through HOLD and then idles.
- CLEAR mid-transaction does not affect o_pwm_data, which was already latched.
- Fill count is LGFIFO+1 bits.
  - Simultaneous push and pop leaves it unchanged.
  - Read/write pointers wrap modulo 2**LGFIFO.

Decomposition:
- Package pwm_feeder_pkg holds:
  - FSM state enum (IDLE/BUS/WAIT/HOLD).
  - Address constants ADDR_DATA=0, ADDR_CTRL=1.
  - Control bit positions (ENABLE, CLEAR, CLRFLAGS).
  - Status bit positions (ENABLE, EMPTY, FULL, UNF, OVF, FILL_LSB=8).
- One sub-module, pwm_sfifo: synchronous FIFO with push/pop/clear, full/empty and fill count, parameterised by LGFIFO and width 32.
  - The top level holds the register file and master FSM.

Test Plan:
- Reset, write 0x0000_1234 then 0x0001_0000 to address 0 -> status read shows fill=2, empty=0, ENABLE=0; no master cycle while i_pwm_int=1.
- Write ENABLE=1, pulse i_pwm_int high until ack -> exactly one master write of 0x0000_1234 at addr 0.
  - With i_pwm_stall=1 for 3 cycles, stb and data hold steady.
  - Then HOLD for 1 cycle, fill=1.
- Enabled with FIFO empty, i_pwm_int=1 -> master writes 32'h0 and UNF=1.
  - Write CLRFLAGS -> UNF=0.
- Write 33 words with LGFIFO=5 -> fill=32, full=1, OVF=1, 33rd word absent after 32 pops.
  - o_int=0 while fill >= 16; it rises when fill drops to 15.
- Assert i_reset while in WAIT -> o_pwm_cyc=0 immediately, fill=0, ENABLE=0.
  - After release, no write occurs until re-enabled.
- Same-cycle CLEAR write and address-0 push while the FSM is in BUS -> FIFO empty afterwards, in-flight o_pwm_data unchanged and completed.

Source files
------------

// File: rtl/pwm_feeder_pkg.sv
// Shared constants for the PWM sample feeder: register map, control/status
// bit positions and the master-side transaction state encoding.
package pwm_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fsm_state_t;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CLEAR    = 1;
  localparam int CTRL_CLRFLAGS = 2;

  localparam int STAT_ENABLE   = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_FULL     = 2;
  localparam int STAT_UNF      = 3;
  localparam int STAT_OVF      = 4;
  localparam int STAT_FILL_LSB = 8;

  // Written on underflow: midscale sample, bit16 clear so aux bits are untouched.
  localparam logic [31:0] UNDERFLOW_WORD = 32'h0000_0000;

endpackage

// File: rtl/pwm_sfifo.sv
// Synchronous sample FIFO with push/pop/clear, full/empty flags and fill count.
module pwm_sfifo #(
  parameter int LGFIFO = 5,
  parameter int WIDTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_pop,
  input  logic              i_clear,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LGFIFO:0]   o_fill
);

  localparam int DEPTH = 1 << LGFIFO;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFIFO:0]   fill_q, fill_d;
  logic              do_push, do_pop;

  assign o_full  = (fill_q == DEPTH[LGFIFO:0]);
  assign o_empty = (fill_q == '0);
  assign o_fill  = fill_q;
  assign o_data  = mem_q[rd_ptr_q];

  // Full/empty are judged on the pre-edge fill, so a push into a full FIFO
  // is dropped even when a pop happens on the same cycle.
  always_comb begin
    do_push  = i_push & ~o_full & ~i_clear;
    do_pop   = i_pop & ~o_empty & ~i_clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + LGFIFO'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + LGFIFO'(1);
      case ({do_push, do_pop})
        2'b10:   fill_d = fill_q + (LGFIFO+1)'(1);
        2'b01:   fill_d = fill_q - (LGFIFO+1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/pwm_sample_feeder.sv
// CPU-facing sample buffer for the Wishbone PWM audio controller: buffers
// samples from a slave port and forwards one per controller request.
module pwm_sample_feeder
  import pwm_feeder_pkg::*;
#(
  parameter int LGFIFO = 5,
  parameter int NAUX   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic        i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_pwm_cyc,
  output logic        o_pwm_stb,
  output logic        o_pwm_we,
  output logic        o_pwm_addr,
  output logic [31:0] o_pwm_data,
  input  logic        i_pwm_ack,
  input  logic        i_pwm_stall,
  input  logic        i_pwm_int,
  output logic        o_int
);

  if (LGFIFO < 2 || LGFIFO > 7) begin : g_bad_lgfifo
    $error("pwm_sample_feeder: LGFIFO must be within 2..7");
  end
  if (NAUX < 0 || NAUX > 12) begin : g_bad_naux
    $error("pwm_sample_feeder: aux field must fit in data[31:20]");
  end

  localparam int HALF_FILL = 1 << (LGFIFO - 1);

  logic              enable_q, enable_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              int_q, int_d;
  fsm_state_t        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic [31:0]       pdata_q, pdata_d;

  logic              wr_req, data_wr, ctrl_wr;
  logic              ctrl_clear, ctrl_clrflags;
  logic              set_ovf, set_unf;
  logic              fifo_pop;
  logic [31:0]       fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [LGFIFO:0]   fifo_fill;
  logic [31:0]       status_word;

  pwm_sfifo #(
    .LGFIFO (LGFIFO),
    .WIDTH  (32)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (data_wr),
    .i_data  (i_wb_data),
    .i_pop   (fifo_pop),
    .i_clear (ctrl_clear),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_fill  (fifo_fill)
  );

  always_comb begin
    wr_req        = i_wb_cyc & i_wb_stb & i_wb_we;
    data_wr       = wr_req & (i_wb_addr == ADDR_DATA);
    ctrl_wr       = wr_req & (i_wb_addr == ADDR_CTRL);
    ctrl_clear    = ctrl_wr & i_wb_data[CTRL_CLEAR];
    ctrl_clrflags = ctrl_wr & i_wb_data[CTRL_CLRFLAGS];
    set_ovf       = data_wr & fifo_full;
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_FILL_LSB +: LGFIFO+1] = fifo_fill;
    status_word[STAT_OVF]    = ovf_q;
    status_word[STAT_UNF]    = unf_q;
    status_word[STAT_FULL]   = fifo_full;
    status_word[STAT_EMPTY]  = fifo_empty;
    status_word[STAT_ENABLE] = enable_q;
  end

  // Slave side never stalls; ack and read data follow the strobe by one cycle.
  always_comb begin
    ack_d   = i_wb_stb;
    rdata_d = rdata_q;
    if (i_wb_stb) begin
      rdata_d = (i_wb_addr == ADDR_CTRL) ? {31'b0, enable_q} : status_word;
    end
    enable_d = ctrl_wr ? i_wb_data[CTRL_ENABLE] : enable_q;
    ovf_d    = (ovf_q & ~ctrl_clrflags) | set_ovf;
    unf_d    = (unf_q & ~ctrl_clrflags) | set_unf;
    int_d    = enable_q & (fifo_fill < HALF_FILL[LGFIFO:0]);
  end

  // Master handshake: stb marks a valid write beat, !i_pwm_stall is ready;
  // the beat transfers on stb & !stall, and the cycle ends on i_pwm_ack.
  // HOLD gives the controller one cycle to drop its request line.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    pdata_d  = pdata_q;
    fifo_pop = 1'b0;
    set_unf  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_q & i_pwm_int) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          if (!fifo_empty) begin
            pdata_d  = fifo_rdata;
            fifo_pop = 1'b1;
          end else begin
            pdata_d = UNDERFLOW_WORD;
            set_unf = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (!i_pwm_stall) begin
          stb_d = 1'b0;
          if (i_pwm_ack) begin
            cyc_d   = 1'b0;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_pwm_ack) begin
          cyc_d   = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      int_q    <= 1'b0;
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      pdata_q  <= '0;
    end else begin
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      int_q    <= int_d;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      pdata_q  <= pdata_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = 1'b0;
  assign o_wb_data  = rdata_q;
  assign o_pwm_cyc  = cyc_q;
  assign o_pwm_stb  = stb_q;
  assign o_pwm_we   = cyc_q;
  assign o_pwm_addr = 1'b0;
  assign o_pwm_data = pdata_q;
  assign o_int      = int_q;

endmodule
